// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - layer sequencer bus: start/status, activation/weight reads, neuron lanes, result writes
interface layer_sequencer_if #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 20
);
  localparam int XAW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int YAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [XAW-1:0]        x_addr;
  logic [XAW-1:0]        w_addr;
  logic [15:0]           x_rdata;
  logic                  active;
  logic [15:0]           x;
  logic [16*N_OUT-1:0]   z;
  logic                  y_we;
  logic [YAW-1:0]        y_addr;
  logic [15:0]           y_data;

  // master: the surrounding layer (memories, neurons, controller)
  modport master (
    output start, x_rdata, z,
    input  busy, done, x_addr, w_addr, active, x, y_we, y_addr, y_data
  );

  // slave: the sequencer itself
  modport slave (
    input  start, x_rdata, z,
    output busy, done, x_addr, w_addr, active, x, y_we, y_addr, y_data
  );
endinterface

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - walks activations/weights into a MAC bank, captures and writes its N_OUT results
// Define LAYER_SEQ_RELU_EN to clamp negative results to zero before writing (hidden layers).
module layer_sequencer #(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 20,
  parameter int RD_LAT  = 2,
  parameter int MAC_LAT = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  layer_sequencer_if.slave bus_if
);
  localparam int XAW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int YAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int D    = RD_LAT + MAC_LAT + 1;
  localparam int M1   = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int CMAX = (M1 > D) ? M1 : D;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]  LOAD_LAST  = CW'(N_IN - 1);
  localparam logic [CW-1:0]  DRAIN_LAST = CW'(D - 1);
  localparam logic [CW-1:0]  WRITE_LAST = CW'(N_OUT - 1);
  localparam logic [XAW-1:0] HOLD_ADDR  = XAW'(N_IN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_CAPTURE, S_WRITE, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [16*N_OUT-1:0] res_q, res_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                active_q, active_d;
  logic                y_we_q, y_we_d;
  logic [XAW-1:0]      addr_q, addr_d;
  logic [YAW-1:0]      y_addr_q, y_addr_d;
  logic [15:0]         x_q, x_d;
  logic [15:0]         y_data_q, y_data_d;
  logic [15:0]         lane;
  logic [15:0]         lane_proc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_WRITE;
        cnt_d   = '0;
      end
      S_WRITE: begin
        if (cnt_q == WRITE_LAST) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The first write lane is selected in the same edge that latches Z, so read through res_d.
    res_d = (state_q == S_CAPTURE) ? bus_if.z : res_q;
    lane  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (cnt_d == CW'(i)) lane = res_d[16*i +: 16];
    end
`ifdef LAYER_SEQ_RELU_EN
    lane_proc = lane[15] ? 16'h0000 : lane;
`else
    lane_proc = lane;
`endif

    // vld_q[k] marks x_rdata of address k+1 cycles old; the top stage is the valid window.
    vld_d = RD_LAT'({vld_q, (state_d == S_LOAD)});
    x_d   = vld_q[RD_LAT-1] ? bus_if.x_rdata : 16'h0000;

    addr_d = '0;
    if (state_d == S_LOAD) begin
      addr_d = XAW'(cnt_d);
    end else if (state_d == S_DRAIN) begin
      addr_d = HOLD_ADDR;
    end

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);
    active_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
    y_we_d   = (state_d == S_WRITE);
    y_addr_d = (state_d == S_WRITE) ? YAW'(cnt_d) : '0;
    y_data_d = (state_d == S_WRITE) ? lane_proc : 16'h0000;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      vld_q    <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      y_we_q   <= 1'b0;
      addr_q   <= '0;
      y_addr_q <= '0;
      x_q      <= '0;
      y_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      active_q <= active_d;
      y_we_q   <= y_we_d;
      addr_q   <= addr_d;
      y_addr_q <= y_addr_d;
      x_q      <= x_d;
      y_data_q <= y_data_d;
    end
  end

  assign bus_if.busy   = busy_q;
  assign bus_if.done   = done_q;
  assign bus_if.active = active_q;
  assign bus_if.x      = x_q;
  assign bus_if.x_addr = addr_q;
  assign bus_if.w_addr = addr_q;
  assign bus_if.y_we   = y_we_q;
  assign bus_if.y_addr = y_addr_q;
  assign bus_if.y_data = y_data_q;
endmodule
